reg_wb_arbiter: RTL and testbench

- Shares the register file's single write port (WRVALID/WRADDR/WRDATA) between two writeback sources.
- Source 1 is the in-order ALU writeback stage. Source 2 is out-of-band load (LSU) responses.
- LSU responses are buffered in a small FIFO and drained when the ALU path is idle. A starvation counter requests a pipeline bubble so buffered loads always drain.
- Read-address hazard flags tell the decode stage when a source register still has a load writeback pending.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/wb_fifo.sv | 80 ++++++++
 rtl/reg_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared register-file widths and the writeback entry type.
// Revision: 1.0
// ============================================================================
package cpu_pkg;

    localparam int              REG_ADDR_W = 5;
    localparam int              XLEN       = 32;
    localparam logic [4:0]      REG_ZERO   = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// wb_fifo : load-writeback buffer; exposes per-entry valid/address for hazards.
// Revision: 1.0
// ============================================================================
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_push,
    input  wb_entry_t                            i_wdata,
    input  logic                                 i_pop,
    output wb_entry_t                            o_rdata,
    output logic                                 o_full,
    output logic                                 o_empty,
    output logic [DEPTH-1:0]                     o_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     o_addr
);

    localparam int               PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   C_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   C_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] C_STEP = PTR_W'(1);

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [DEPTH-1:0]   r_valid;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == C_FULL);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_valid = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr          <= r_wr_ptr + C_STEP;
                r_valid[r_wr_ptr] <= 1'b1;
            end
            // A push into a non-full FIFO never targets the slot being popped.
            if (w_pop) begin
                r_rd_ptr          <= r_rd_ptr + C_STEP;
                r_valid[r_rd_ptr] <= 1'b0;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - C_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_addr
            assign o_addr[gi] = r_mem[gi].addr;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// reg_wb_arbiter : shares the register-file write port between ALU writeback
// and buffered load responses. Optional macro REG_WB_BYPASS_EN lets a load skip
// the empty FIFO when the ALU is idle.
// Revision: 1.0
// ============================================================================
module reg_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  STALL,
    input  logic                  FLUSH,
    input  logic                  ALU_VALID,
    input  logic [REG_ADDR_W-1:0] ALU_ADDR,
    input  logic [XLEN-1:0]       ALU_DATA,
    input  logic                  LSU_VALID,
    output logic                  LSU_READY,
    input  logic [REG_ADDR_W-1:0] LSU_ADDR,
    input  logic [XLEN-1:0]       LSU_DATA,
    input  logic [REG_ADDR_W-1:0] RDADDR_1,
    input  logic [REG_ADDR_W-1:0] RDADDR_2,
    output logic                  HAZARD_1,
    output logic                  HAZARD_2,
    output logic                  WB_STALL,
    output logic                  WRVALID,
    output logic [REG_ADDR_W-1:0] WRADDR,
    output logic [XLEN-1:0]       WRDATA
);

    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] C_INC = CNT_W'(1);

    logic                                  r_wrvalid;
    logic [REG_ADDR_W-1:0]                 r_wraddr;
    logic [XLEN-1:0]                       r_wrdata;
    logic [CNT_W-1:0]                      r_cnt;
    logic                                  r_wb_stall;
    logic [CNT_W-1:0]                      w_cnt_next;
    logic                                  w_alu_win;
    logic                                  w_lsu_take;
    logic                                  w_bypass;
    logic                                  w_fifo_push;
    logic                                  w_pop;
    logic                                  w_full;
    logic                                  w_empty;
    wb_entry_t                             w_head;
    wb_entry_t                             w_lsu_entry;
    logic [FIFO_DEPTH-1:0]                 w_fvalid;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] w_faddr;
    logic                                  w_hit_1;
    logic                                  w_hit_2;

    assign w_alu_win   = ALU_VALID && !FLUSH && (ALU_ADDR != REG_ZERO);
    assign w_lsu_take  = LSU_VALID && LSU_READY && (LSU_ADDR != REG_ZERO);
    assign w_pop       = !STALL && !w_alu_win && !w_empty;
`ifdef REG_WB_BYPASS_EN
    assign w_bypass    = !STALL && !w_alu_win && w_empty && w_lsu_take;
`else
    assign w_bypass    = 1'b0;
`endif
    assign w_fifo_push = w_lsu_take && !w_bypass;
    assign w_lsu_entry = '{addr: LSU_ADDR, data: LSU_DATA};
    assign LSU_READY   = !w_full;

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .i_push  (w_fifo_push),
        .i_wdata (w_lsu_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_valid (w_fvalid),
        .o_addr  (w_faddr)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wrvalid <= 1'b0;
            r_wraddr  <= '0;
            r_wrdata  <= '0;
        end else if (!STALL) begin
            if (w_alu_win) begin
                r_wrvalid <= 1'b1;
                r_wraddr  <= ALU_ADDR;
                r_wrdata  <= ALU_DATA;
            end else if (w_pop) begin
                r_wrvalid <= 1'b1;
                r_wraddr  <= w_head.addr;
                r_wrdata  <= w_head.data;
            end else if (w_bypass) begin
                r_wrvalid <= 1'b1;
                r_wraddr  <= LSU_ADDR;
                r_wrdata  <= LSU_DATA;
            end else begin
                r_wrvalid <= 1'b0;
            end
        end
    end

    // Counts cycles the buffered head loses to the ALU; saturates at the limit.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_empty || w_pop) begin
            w_cnt_next = '0;
        end else if (!STALL && w_alu_win && (r_cnt != C_MAX)) begin
            w_cnt_next = r_cnt + C_INC;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt      <= '0;
            r_wb_stall <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_wb_stall <= (w_cnt_next == C_MAX);
        end
    end

    always_comb begin
        w_hit_1 = 1'b0;
        w_hit_2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_fvalid[i] && (w_faddr[i] == RDADDR_1)) w_hit_1 = 1'b1;
            if (w_fvalid[i] && (w_faddr[i] == RDADDR_2)) w_hit_2 = 1'b1;
        end
        if (w_fifo_push && (LSU_ADDR == RDADDR_1)) w_hit_1 = 1'b1;
        if (w_fifo_push && (LSU_ADDR == RDADDR_2)) w_hit_2 = 1'b1;
        if (r_wrvalid && (r_wraddr == RDADDR_1))   w_hit_1 = 1'b1;
        if (r_wrvalid && (r_wraddr == RDADDR_2))   w_hit_2 = 1'b1;
    end

    assign HAZARD_1 = (RDADDR_1 != REG_ZERO) && w_hit_1;
    assign HAZARD_2 = (RDADDR_2 != REG_ZERO) && w_hit_2;
    assign WB_STALL = r_wb_stall;
    assign WRVALID  = r_wrvalid;
    assign WRADDR   = r_wraddr;
    assign WRDATA   = r_wrdata;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_reg_wb_arbiter : directed-vector bench for reg_wb_arbiter.
// Revision: 1.0
// ============================================================================
module tb_reg_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        STALL;
    logic        FLUSH;
    logic        ALU_VALID;
    logic [4:0]  ALU_ADDR;
    logic [31:0] ALU_DATA;
    logic        LSU_VALID;
    logic        LSU_READY;
    logic [4:0]  LSU_ADDR;
    logic [31:0] LSU_DATA;
    logic [4:0]  RDADDR_1;
    logic [4:0]  RDADDR_2;
    logic        HAZARD_1;
    logic        HAZARD_2;
    logic        WB_STALL;
    logic        WRVALID;
    logic [4:0]  WRADDR;
    logic [31:0] WRDATA;

    int n_vec = 0;
    int n_err = 0;

    reg_wb_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .STALL     (STALL),
        .FLUSH     (FLUSH),
        .ALU_VALID (ALU_VALID),
        .ALU_ADDR  (ALU_ADDR),
        .ALU_DATA  (ALU_DATA),
        .LSU_VALID (LSU_VALID),
        .LSU_READY (LSU_READY),
        .LSU_ADDR  (LSU_ADDR),
        .LSU_DATA  (LSU_DATA),
        .RDADDR_1  (RDADDR_1),
        .RDADDR_2  (RDADDR_2),
        .HAZARD_1  (HAZARD_1),
        .HAZARD_2  (HAZARD_2),
        .WB_STALL  (WB_STALL),
        .WRVALID   (WRVALID),
        .WRADDR    (WRADDR),
        .WRDATA    (WRDATA)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        ALU_VALID = v;
        ALU_ADDR  = a;
        ALU_DATA  = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
        LSU_VALID = v;
        LSU_ADDR  = a;
        LSU_DATA  = d;
    endtask

    task automatic chk_wr(input string tag, input logic v, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".v"}, {31'd0, WRVALID}, {31'd0, v});
        if (v) begin
            chk({tag, ".a"}, {27'd0, WRADDR}, {27'd0, a});
            chk({tag, ".d"}, WRDATA, d);
        end
    endtask

    initial begin
        RST = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        RDADDR_1 = 5'd0; RDADDR_2 = 5'd0;
        tick(); tick();
        chk("rst.wrvalid", {31'd0, WRVALID}, 32'd0);
        chk("rst.wraddr", {27'd0, WRADDR}, 32'd0);
        chk("rst.wrdata", WRDATA, 32'd0);
        chk("rst.wbstall", {31'd0, WB_STALL}, 32'd0);
        chk("rst.ready", {31'd0, LSU_READY}, 32'd1);
        RST = 1'b1;
        tick();

        // ALU-only writes, x0 drop, flush
        alu(1'b1, 5'd5, 32'h0000_1234);
        tick();
        chk_wr("alu5", 1'b1, 5'd5, 32'h0000_1234);
        alu(1'b1, 5'd0, 32'hFFFF_FFFF);
        RDADDR_1 = 5'd5;
        #1;
        chk("haz.outreg", {31'd0, HAZARD_1}, 32'd1);
        tick();
        chk_wr("alu0", 1'b0, 5'd0, 32'd0);
        alu(1'b1, 5'd6, 32'h0000_0066);
        FLUSH = 1'b1;
        tick();
        chk_wr("flush", 1'b0, 5'd0, 32'd0);
        FLUSH = 1'b0;
        alu(1'b0, 5'd0, 32'd0);
        RDADDR_1 = 5'd0;

        // LSU write to x0 handshakes but never writes
        lsu(1'b1, 5'd0, 32'hDEAD_BEEF);
        #1;
        chk("lsu0.ready", {31'd0, LSU_READY}, 32'd1);
        tick();
        lsu(1'b0, 5'd0, 32'd0);
        tick();
        chk_wr("lsu0", 1'b0, 5'd0, 32'd0);

        // collision: ALU wins, load follows one cycle later
        alu(1'b1, 5'd3, 32'h0000_000A);
        lsu(1'b1, 5'd7, 32'h0000_000B);
        tick();
        chk_wr("coll.alu", 1'b1, 5'd3, 32'h0000_000A);
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        RDADDR_2 = 5'd7;
        #1;
        chk("haz.fifo", {31'd0, HAZARD_2}, 32'd1);
        tick();
        chk_wr("coll.lsu", 1'b1, 5'd7, 32'h0000_000B);
        tick();
        chk_wr("coll.idle", 1'b0, 5'd0, 32'd0);
        chk("haz.clear", {31'd0, HAZARD_2}, 32'd0);
        RDADDR_2 = 5'd0;

        // lone load with ALU idle
        lsu(1'b1, 5'd7, 32'h0000_000C);
        tick();
        lsu(1'b0, 5'd0, 32'd0);
`ifdef REG_WB_BYPASS_EN
        chk_wr("bypass.t1", 1'b1, 5'd7, 32'h0000_000C);
        tick();
        chk_wr("bypass.t2", 1'b0, 5'd0, 32'd0);
`else
        chk_wr("lsu.t1", 1'b0, 5'd0, 32'd0);
        tick();
        chk_wr("lsu.t2", 1'b1, 5'd7, 32'h0000_000C);
`endif
        tick();

        // fill FIFO while ALU busy
        for (int i = 0; i < 4; i++) begin
            alu(1'b1, 5'd1, 32'(i));
            lsu(1'b1, 5'(8 + i), 32'h100 + 32'(i));
            tick();
        end
        lsu(1'b0, 5'd0, 32'd0);
        RDADDR_1 = 5'd9; RDADDR_2 = 5'd12;
        #1;
        chk("full.ready", {31'd0, LSU_READY}, 32'd0);
        chk("full.haz1", {31'd0, HAZARD_1}, 32'd1);
        chk("full.haz2", {31'd0, HAZARD_2}, 32'd0);
        chk("full.wbstall", {31'd0, WB_STALL}, 32'd0);
        alu(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_wr("drain", 1'b1, 5'(8 + i), 32'h100 + 32'(i));
            chk("drain.ready", {31'd0, LSU_READY}, 32'd1);
        end
        tick();
        chk_wr("drain.end", 1'b0, 5'd0, 32'd0);
        RDADDR_1 = 5'd0; RDADDR_2 = 5'd0;

        // starvation: queued x4 loses to the ALU for 8 cycles
        alu(1'b1, 5'd1, 32'h0000_0011);
        lsu(1'b1, 5'd4, 32'h0000_0044);
        tick();
        lsu(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 7; i++) tick();
        chk("starve.7", {31'd0, WB_STALL}, 32'd0);
        tick();
        chk("starve.8", {31'd0, WB_STALL}, 32'd1);
        chk_wr("starve.alu", 1'b1, 5'd1, 32'h0000_0011);
        alu(1'b0, 5'd0, 32'd0);
        tick();
        chk_wr("starve.pop", 1'b1, 5'd4, 32'h0000_0044);
        chk("starve.clr", {31'd0, WB_STALL}, 32'd0);
        tick();

        // STALL holds output and FIFO
        alu(1'b1, 5'd2, 32'h0000_0055);
        lsu(1'b1, 5'd12, 32'h0000_0066);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        STALL = 1'b1;
        RDADDR_1 = 5'd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_wr("stall.hold", 1'b1, 5'd2, 32'h0000_0055);
            chk("stall.fifo", {31'd0, HAZARD_1}, 32'd1);
        end
        STALL = 1'b0;
        tick();
        chk_wr("stall.resume", 1'b1, 5'd12, 32'h0000_0066);
        tick();
        chk_wr("stall.empty", 1'b0, 5'd0, 32'd0);
        chk("stall.hazclr", {31'd0, HAZARD_1}, 32'd0);
        RDADDR_1 = 5'd0;

        // reset mid-drain
        for (int i = 0; i < 3; i++) begin
            alu(1'b1, 5'd1, 32'h0000_0001);
            lsu(1'b1, 5'(20 + i), 32'h200 + 32'(i));
            tick();
        end
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        tick();
        chk_wr("mid.pop", 1'b1, 5'd20, 32'h0000_0200);
        RDADDR_1 = 5'd21; RDADDR_2 = 5'd22;
        #1;
        chk("mid.haz", {31'd0, HAZARD_1}, 32'd1);
        RST = 1'b0;
        #1;
        chk("mrst.wrvalid", {31'd0, WRVALID}, 32'd0);
        chk("mrst.wbstall", {31'd0, WB_STALL}, 32'd0);
        chk("mrst.ready", {31'd0, LSU_READY}, 32'd1);
        chk("mrst.haz1", {31'd0, HAZARD_1}, 32'd0);
        chk("mrst.haz2", {31'd0, HAZARD_2}, 32'd0);
        tick();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post.wrvalid", {31'd0, WRVALID}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
